// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the two-master AXI4-Lite arbiter.
//   state_t      : arbiter FSM states
//   op_t         : operation kind used for write/read alternation
//   RESP_*       : AXI response codes
//   pick_master  : round-robin master choice
//   pick_write   : write/read alternation inside the chosen master
package axil_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        WR_RET   = 3'd3,
        RD_ISSUE = 3'd4,
        RD_RESP  = 3'd5,
        RD_RET   = 3'd6
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // On a tie the master that did not win last time is chosen.
    function automatic logic pick_master(input logic req0, input logic req1,
                                         input logic rr_last);
        return (req0 && req1) ? ~rr_last : req1;
    endfunction

    // Returns 1 for write. With both pending, take the opposite of the last op.
    function automatic logic pick_write(input logic wr, input logic rd,
                                        input op_t op_last);
        return (wr && rd) ? (op_last == OP_READ) : wr;
    endfunction

endpackage

// File: rtl/axil_arbiter_2to1.sv
// Two-to-one AXI4-Lite arbiter in front of the register-file slave.
// s0 = PCIe bridge master, s1 = local fabric master. One transaction in flight.
// Ports:
//   axi_aclk / axi_aresetn : clock, asynchronous active-low reset
//   s0_* / s1_*            : AXI4-Lite slave ports facing the two masters
//   m_*                    : AXI4-Lite master port facing the register file
//   grant                  : master owning the current/last transaction
//   busy                   : high whenever the FSM is not IDLE
module axil_arbiter_2to1
    import axil_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 40,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    axi_aclk,
    input  logic                    axi_aresetn,
    // master 0
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [2:0]              s0_awprot,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    output logic [1:0]              s0_bresp,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [2:0]              s0_arprot,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    // master 1
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [2:0]              s1_awprot,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    output logic [1:0]              s1_bresp,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [2:0]              s1_arprot,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    // toward the register file
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    // status
    output logic                    grant,
    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    state_t state, state_nxt;

    logic                  rr_last;
    op_t                   op_last;
    logic                  grant_q;
    logic                  aw_done, w_done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [1:0]            bresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // Master-side signals gathered into arrays indexed by master number.
    logic [NUM_MASTERS-1:0]                 s_awvalid, s_wvalid, s_arvalid;
    logic [NUM_MASTERS-1:0]                 s_bready, s_rready;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] s_awaddr, s_araddr;
    logic [NUM_MASTERS-1:0][2:0]            s_awprot, s_arprot;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] s_wdata;
    logic [NUM_MASTERS-1:0][STRB_WIDTH-1:0] s_wstrb;

    logic [NUM_MASTERS-1:0] aw_rdy, w_rdy, ar_rdy, b_vld, r_vld;

    assign s_awvalid = {s1_awvalid, s0_awvalid};
    assign s_wvalid  = {s1_wvalid,  s0_wvalid};
    assign s_arvalid = {s1_arvalid, s0_arvalid};
    assign s_bready  = {s1_bready,  s0_bready};
    assign s_rready  = {s1_rready,  s0_rready};
    assign s_awaddr  = {s1_awaddr,  s0_awaddr};
    assign s_araddr  = {s1_araddr,  s0_araddr};
    assign s_awprot  = {s1_awprot,  s0_awprot};
    assign s_arprot  = {s1_arprot,  s0_arprot};
    assign s_wdata   = {s1_wdata,   s0_wdata};
    assign s_wstrb   = {s1_wstrb,   s0_wstrb};

    // Request decode. A write needs address and data together; a lone
    // awvalid or wvalid is not a request.
    logic [NUM_MASTERS-1:0] wr_req, rd_req, any_req;
    logic                   accept, sel_m, sel_wr;

    assign wr_req  = s_awvalid & s_wvalid;
    assign rd_req  = s_arvalid;
    assign any_req = wr_req | rd_req;
    assign accept  = (state == IDLE) && (|any_req);
    assign sel_m   = pick_master(any_req[0], any_req[1], rr_last);
    assign sel_wr  = pick_write(wr_req[sel_m], rd_req[sel_m], op_last);

    // ---------------- state register ----------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= IDLE;
        else              state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = sel_wr ? WR_ISSUE : RD_ISSUE;
            // Address and data may finish in either order or together.
            WR_ISSUE: if ((aw_done || m_awready) && (w_done || m_wready))
                          state_nxt = WR_RESP;
            WR_RESP:  if (m_bvalid) state_nxt = WR_RET;
            WR_RET:   if (s_bready[grant_q]) state_nxt = IDLE;
            RD_ISSUE: if (m_arready) state_nxt = RD_RESP;
            RD_RESP:  if (m_rvalid) state_nxt = RD_RET;
            RD_RET:   if (s_rready[grant_q]) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        aw_rdy    = '0;
        w_rdy     = '0;
        ar_rdy    = '0;
        b_vld     = '0;
        r_vld     = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_wr) begin
                        aw_rdy[sel_m] = 1'b1;
                        w_rdy[sel_m]  = 1'b1;
                    end else begin
                        ar_rdy[sel_m] = 1'b1;
                    end
                end
            end
            WR_ISSUE: begin
                m_awvalid = !aw_done;
                m_wvalid  = !w_done;
            end
            WR_RESP:  m_bready = 1'b1;
            WR_RET:   b_vld[grant_q] = 1'b1;
            RD_ISSUE: m_arvalid = 1'b1;
            RD_RESP:  m_rready = 1'b1;
            RD_RET:   r_vld[grant_q] = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath / bookkeeping ----------------
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rr_last <= 1'b1;        // so s0 wins the first tie
            op_last <= OP_READ;
            grant_q <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            prot_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            if (accept) begin
                grant_q <= sel_m;
                rr_last <= sel_m;
                op_last <= sel_wr ? OP_WRITE : OP_READ;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                // One address register serves both channels; only one
                // transaction exists at a time.
                if (sel_wr) begin
                    addr_q  <= s_awaddr[sel_m];
                    prot_q  <= s_awprot[sel_m];
                    wdata_q <= s_wdata[sel_m];
                    wstrb_q <= s_wstrb[sel_m];
                end else begin
                    addr_q  <= s_araddr[sel_m];
                    prot_q  <= s_arprot[sel_m];
                end
            end
            if (state == WR_ISSUE) begin
                if (m_awvalid && m_awready) aw_done <= 1'b1;
                if (m_wvalid && m_wready)   w_done  <= 1'b1;
            end
            if (state == WR_RESP && m_bvalid) bresp_q <= m_bresp;
            if (state == RD_RESP && m_rvalid) begin
                rdata_q <= m_rdata;
                rresp_q <= m_rresp;
            end
        end
    end

    assign m_awaddr = addr_q;
    assign m_awprot = prot_q;
    assign m_araddr = addr_q;
    assign m_arprot = prot_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = wstrb_q;

    assign s0_awready = aw_rdy[0];
    assign s1_awready = aw_rdy[1];
    assign s0_wready  = w_rdy[0];
    assign s1_wready  = w_rdy[1];
    assign s0_arready = ar_rdy[0];
    assign s1_arready = ar_rdy[1];
    assign s0_bvalid  = b_vld[0];
    assign s1_bvalid  = b_vld[1];
    assign s0_rvalid  = r_vld[0];
    assign s1_rvalid  = r_vld[1];

    // Response payload is shown only to the granted master.
    assign s0_bresp = grant_q ? 2'b00 : bresp_q;
    assign s1_bresp = grant_q ? bresp_q : 2'b00;
    assign s0_rresp = grant_q ? 2'b00 : rresp_q;
    assign s1_rresp = grant_q ? rresp_q : 2'b00;
    assign s0_rdata = grant_q ? '0 : rdata_q;
    assign s1_rdata = grant_q ? rdata_q : '0;

    assign grant = grant_q;
    assign busy  = (state != IDLE);

endmodule
